reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Integer register file for the reduced RISC-V core, at the other end of the ALU operand/result interface.
//  Supplies ALUop1 / regOp2 from two combinational read ports and accepts the ALU/writeback result on one write port.
//  A per-register pending-write scoreboard raises a stall when an issuing instruction reads a register
//  whose value is still in flight.
//  Sits between decode (read/issue side) and writeback (write side).
// PARAMETERS
//  DATAWIDTH  32  register and data width in bits
//  ADDRWIDTH  5   register index width; 2**ADDRWIDTH registers, x0 hardwired to zero
// PORTS
//  clk          in   1          clock; all state updates on posedge
//  rst_n        in   1          synchronous active-low reset
//  AD1          in   ADDRWIDTH  read port 1 index (rs1)
//  AD2          in   ADDRWIDTH  read port 2 index (rs2)
//  RD1          out  DATAWIDTH  read port 1 data -> ALUop1
//  RD2          out  DATAWIDTH  read port 2 data -> regOp2
//  issue_valid  in   1          decode presents an instruction for issue this cycle
//  issue_rd     in   ADDRWIDTH  destination of issuing instruction
//  stall        out  1          issue blocked by RAW hazard on AD1/AD2
//  WE3          in   1          writeback enable
//  AD3          in   ADDRWIDTH  writeback index
//  WD3          in   DATAWIDTH  writeback data (ALUout or load data)
//  pending_cnt  out  ADDRWIDTH+1  number of registers currently marked busy
//  a0           out  DATAWIDTH  current value of x10 (debug/test output)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): all registers <= 0, all busy bits <= 0, pending_cnt <= 0; a WE3 or issue
//    in the reset cycle is discarded. Reset mid-operation drops all pending writes. After reset: RD1/RD2/a0 = 0, stall = 0.
//  - x0: reads always 0; writes ignored; never marked busy; never causes stall.
//  - Reads combinational. Bypass: if WE3 && AD3==ADn && ADn!=0 then RDn = WD3 (write-first), else RDn = reg[ADn].
//  - Write: at posedge with rst_n=1, WE3 && AD3!=0 -> reg[AD3] <= WD3; busy[AD3] <= 0.
//  - stall = issue_valid && (hz(AD1) || hz(AD2)); hz(a) = a!=0 && busy[a] && !(WE3 && AD3==a).
//    Both read indices always checked (no rs-used qualifiers). stall is combinational, 0-cycle latency.
//  - Issue: at posedge, issue_valid && !stall && issue_rd!=0 -> busy[issue_rd] <= 1. Stalled issue sets nothing;
//    decode holds its inputs and retries.
//  - Same-cycle issue_rd == AD3 (write completes, new producer issues): set wins; busy stays 1, data written.
//  - Issue to an already-busy rd (WAW) is permitted; busy stays 1; the first writeback clears it.
//  - WE3 to a non-busy register: data written, busy unchanged (0).
//  - pending_cnt == popcount(busy) at all times; single-cycle update: +1 on 0->1 set, -1 on 1->0 clear, net on
//    simultaneous events on different indices; never wraps (max 2**ADDRWIDTH-1).
//  - a0 = reg[10], registered (no bypass): new value visible the cycle after the write.
// TESTING
//  1. Reset, then read all 32 indices -> RD1=RD2=0, a0=0, pending_cnt=0, stall=0.
//  2. WE3=1, AD3=0, WD3=0xDEADBEEF; then AD1=0 -> RD1=0, no busy set; AD3=5, WD3=0x1234, AD1=5 same cycle -> RD1=0x1234 (bypass),
//     next cycle RD1=0x1234 from the array.
//  3. Issue rd=7; next cycle issue_valid with AD2=7 -> stall=1, pending_cnt=1; cycle WE3 AD3=7 WD3=0x55 -> stall=0, RD2=0x55,
//     following cycle pending_cnt=0.
//  4. Same cycle: WE3 AD3=3 and issue rd=3 (not stalled) -> reg[3] written, busy[3]=1, pending_cnt unchanged at 1.
//  5. Issue rd=10 then WE3 AD3=10 WD3=0xA5A5A5A5 -> a0=0xA5A5A5A5 one cycle after the write, not in the same cycle.
//  6. Busy x1, x2 pending (pending_cnt=2), assert rst_n=0 for one cycle with WE3 AD3=1 -> reg[1]=0, pending_cnt=0, stall=0.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb -- integer register file with a pending-write scoreboard.
//
// Two combinational read ports (write-first bypass from the writeback port),
// one synchronous write port, and one busy bit per register. An issuing
// instruction sets busy on its destination. The matching writeback clears it.
// A read of a busy register that is not being written this cycle raises stall.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   AD1/RD1, AD2/RD2  read ports (rs1 -> ALUop1, rs2 -> regOp2)
//   issue_valid       decode presents an instruction this cycle
//   issue_rd          destination of the issuing instruction
//   stall             RAW hazard on AD1/AD2, issue blocked
//   WE3, AD3, WD3     writeback port
//   pending_cnt       number of registers currently marked busy
//   a0                current contents of x10 (no bypass)
module reg_file_sb #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDRWIDTH-1:0] AD1,
  input  logic [ADDRWIDTH-1:0] AD2,
  output logic [DATAWIDTH-1:0] RD1,
  output logic [DATAWIDTH-1:0] RD2,
  input  logic                 issue_valid,
  input  logic [ADDRWIDTH-1:0] issue_rd,
  output logic                 stall,
  input  logic                 WE3,
  input  logic [ADDRWIDTH-1:0] AD3,
  input  logic [DATAWIDTH-1:0] WD3,
  output logic [ADDRWIDTH:0]   pending_cnt,
  output logic [DATAWIDTH-1:0] a0
);

  localparam int NREG = 1 << ADDRWIDTH;

  logic [DATAWIDTH-1:0] regs [NREG];
  logic [NREG-1:0]      busy;
  logic [NREG-1:0]      busy_nxt;
  logic [NREG-1:0]      set_vec;
  logic [NREG-1:0]      clr_vec;
  logic [ADDRWIDTH:0]   pend_q;
  logic                 hz1;
  logic                 hz2;
  logic                 wr_en;

  function automatic logic [ADDRWIDTH:0] popcount(input logic [NREG-1:0] v);
    logic [ADDRWIDTH:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt = cnt + {{ADDRWIDTH{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  // x0 is never a real write target, so it is excluded here once.
  assign wr_en = WE3 && (AD3 != '0);

  // Read ports: a same-cycle writeback to the addressed register is forwarded.
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (AD1 != '0) RD1 = (wr_en && (AD3 == AD1)) ? WD3 : regs[AD1];
    if (AD2 != '0) RD2 = (wr_en && (AD3 == AD2)) ? WD3 : regs[AD2];
  end

  // A busy register being written back this cycle is already resolved by the
  // bypass, so it does not count as a hazard.
  always_comb begin
    hz1   = (AD1 != '0) && busy[AD1] && !(WE3 && (AD3 == AD1));
    hz2   = (AD2 != '0) && busy[AD2] && !(WE3 && (AD3 == AD2));
    stall = issue_valid && (hz1 || hz2);
  end

  // Busy update: clear on writeback, then set on issue, so a new producer
  // issuing to the register being written back keeps it busy.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid && !stall && (issue_rd != '0)) set_vec[issue_rd] = 1'b1;
    if (wr_en) clr_vec[AD3] = 1'b1;
    busy_nxt = (busy & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= '0;
      pend_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      busy   <= busy_nxt;
      pend_q <= popcount(busy_nxt);
      if (wr_en) regs[AD3] <= WD3;
    end
  end

  assign pending_cnt = pend_q;
  assign a0          = regs[10];

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  AD1, AD2, issue_rd, AD3;
  logic [31:0] RD1, RD2, WD3, a0;
  logic        issue_valid, stall, WE3;
  logic [5:0]  pending_cnt;

  always #5 clk = ~clk;

  reg_file_sb #(.DATAWIDTH(32), .ADDRWIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .AD1(AD1), .AD2(AD2), .RD1(RD1), .RD2(RD2),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .stall(stall),
    .WE3(WE3), .AD3(AD3), .WD3(WD3), .pending_cnt(pending_cnt), .a0(a0)
  );

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        stall;
    logic [5:0]  pend;
    logic [31:0] a0;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference state: register contents and the set of in-flight destinations.
  logic [31:0] mem [32];
  bit          pend_set [32];

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (WE3 && AD3 == a) return WD3;
    return mem[a];
  endfunction

  function automatic bit m_hazard(input logic [4:0] a);
    return (a != 0) && pend_set[a] && !(WE3 && AD3 == a);
  endfunction

  function automatic bit m_stall();
    return issue_valid && (m_hazard(AD1) || m_hazard(AD2));
  endfunction

  function automatic logic [5:0] m_count();
    int n = 0;
    for (int i = 0; i < 32; i++) if (pend_set[i]) n++;
    return 6'(n);
  endfunction

  // Apply the clock edge that has just happened, using the inputs held across it.
  task automatic m_edge();
    bit st;
    st = m_stall();
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] = 32'h0;
        pend_set[i] = 1'b0;
      end
    end else begin
      if (WE3 && AD3 != 0) begin
        mem[AD3] = WD3;
        pend_set[AD3] = 1'b0;
      end
      if (issue_valid && !st && issue_rd != 0) pend_set[issue_rd] = 1'b1;
    end
  endtask

  task automatic cyc(input bit rst, input bit iv, input logic [4:0] ird,
                     input logic [4:0] a1, input logic [4:0] a2,
                     input bit we, input logic [4:0] a3, input logic [31:0] wd);
    exp_t e;
    @(posedge clk);
    m_edge();
    #1;
    rst_n = ~rst; issue_valid = iv; issue_rd = ird; AD1 = a1; AD2 = a2;
    WE3 = we; AD3 = a3; WD3 = wd;
    e.rd1   = m_read(AD1);
    e.rd2   = m_read(AD2);
    e.stall = m_stall();
    e.pend  = m_count();
    e.a0    = mem[10];
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents one set of outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("RD1", RD1, e.rd1);
        chk("RD2", RD2, e.rd2);
        chk("stall", {31'b0, stall}, {31'b0, e.stall});
        chk("pending_cnt", {26'b0, pending_cnt}, {26'b0, e.pend});
        chk("a0", a0, e.a0);
      end
    end
  end

  initial begin
    bit          iv, we, rs;
    logic [4:0]  r, x, y, z;
    rst_n = 1'b0; issue_valid = 1'b0; issue_rd = '0; AD1 = '0; AD2 = '0;
    WE3 = 1'b0; AD3 = '0; WD3 = '0;

    // Reset, then sweep every index on both read ports.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) cyc(0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 0);

    // x0 write ignored; bypass then array read of x5.
    cyc(0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 5, 0, 1, 5, 32'h1234);
    cyc(0, 0, 0, 5, 0, 0, 0, 0);

    // RAW hazard on x7, released by its writeback.
    cyc(0, 1, 7, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 7, 0, 0, 0);
    cyc(0, 1, 0, 0, 7, 1, 7, 32'h55);
    cyc(0, 0, 0, 0, 7, 0, 0, 0);

    // Writeback and new issue to x3 in the same cycle: stays busy.
    cyc(0, 1, 3, 0, 0, 0, 0, 0);
    cyc(0, 1, 3, 3, 0, 1, 3, 32'h77);
    cyc(0, 0, 0, 3, 0, 0, 0, 0);
    cyc(0, 1, 0, 3, 0, 1, 3, 32'h88);
    cyc(0, 0, 0, 3, 0, 0, 0, 0);

    // a0 lags the x10 write by one cycle.
    cyc(0, 1, 10, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 10, 0, 1, 10, 32'hA5A5A5A5);
    cyc(0, 0, 0, 10, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset drops pending writes and discards the concurrent writeback.
    cyc(0, 0, 0, 0, 0, 1, 1, 32'h1111);
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 2, 1, 2, 0, 0, 0);
    cyc(1, 0, 0, 1, 2, 1, 1, 32'hFFFF0000);
    cyc(0, 1, 0, 1, 2, 0, 0, 0);
    cyc(0, 0, 0, 1, 2, 0, 0, 0);

    // Randomized traffic over a small index set to provoke hazards and WAW.
    for (int i = 0; i < 3000; i++) begin
      r  = 5'($urandom_range(0, 7)); if ($urandom_range(0, 5) == 0) r = 10;
      x  = 5'($urandom_range(0, 7));
      y  = 5'($urandom_range(0, 7));
      z  = 5'($urandom_range(0, 7)); if ($urandom_range(0, 5) == 0) z = 10;
      iv = ($urandom_range(0, 2) != 0);
      we = ($urandom_range(0, 1) != 0);
      rs = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 20) == 0) r = 5'($urandom);
      cyc(rs, iv, r, x, y, we, z, $urandom);
    end

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
